// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron layer.
// Optional refractory behaviour is enabled in the top with LIF_REFRACTORY_EN.
package lif_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } lif_state_e;

   // Guard bits above MEM_W so decay + sum - threshold cannot wrap before saturation.
   localparam int PRE_GUARD_W = 2;

   // Signed width holding a sum of N_IN terms of +/-1.
   function automatic int sum_w(input int n_in);
      return $clog2(n_in) + 2;
   endfunction

   function automatic int sat_mem(input int v, input int mem_w);
      int hi;
      int lo;
      hi = (1 <<< (mem_w - 1)) - 1;
      lo = -(1 <<< (mem_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Combinational update of one LIF neuron: synapse sum, leak, reset-by-subtraction,
// saturation and threshold compare.
module lif_neuron_core
   import lif_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int MEM_W = 6
) (
   input  logic                    [N_IN-1:0]  in_vec_i,
   input  logic                    [N_IN-1:0]  weights_i,
   input  logic signed             [MEM_W-1:0] mem_i,
   input  logic                                was_spike_i,
   input  logic signed             [MEM_W-1:0] threshold_i,
   input  logic                    [2:0]       shift_i,
   output logic signed             [MEM_W-1:0] mem_o,
   output logic                                spike_o
);

   localparam int SW = sum_w(N_IN);
   localparam int EW = MEM_W + PRE_GUARD_W;

   logic signed [SW-1:0] sum_x;
   logic signed [EW-1:0] u_x;
   logic signed [EW-1:0] beta_x;
   logic signed [EW-1:0] thr_x;
   logic signed [EW-1:0] pre_x;
   int                   sat_i;

   always_comb begin
      sum_x = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (in_vec_i[i]) begin
            sum_x = weights_i[i] ? (sum_x + SW'(1)) : (sum_x - SW'(1));
         end
      end
   end

   always_comb begin
      u_x    = EW'(mem_i);
      // Arithmetic shift keeps the leak rounding towards -inf (u=-1 decays to 0).
      beta_x = (shift_i == 3'd0) ? u_x : (u_x - (u_x >>> shift_i));
      thr_x  = was_spike_i ? EW'(threshold_i) : '0;
      pre_x  = beta_x + EW'(sum_x) - thr_x;
      sat_i  = sat_mem(int'(pre_x), MEM_W);
      mem_o  = MEM_W'(sat_i);
   end

   assign spike_o = (mem_o >= threshold_i);

endmodule

// File: rtl/lif_neuron_layer.sv
// Time-multiplexed layer of LIF neurons: one accepted input vector is one timestep.
// Define LIF_REFRACTORY_EN to add a per-neuron refractory counter (parameter REFRACT).
module lif_neuron_layer
   import lif_pkg::*;
#(
   parameter int N_IN      = 8,
   parameter int N_NEURONS = 4,
   parameter int MEM_W     = 6
`ifdef LIF_REFRACTORY_EN
   ,
   parameter int REFRACT   = 2
`endif
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_we,
   input  logic [$clog2(N_NEURONS)-1:0]     cfg_addr,
   input  logic [N_IN-1:0]                  cfg_weights,
   input  logic signed [MEM_W-1:0]          threshold,
   input  logic [2:0]                       shift,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [N_IN-1:0]                  inputs,
   output logic                             out_valid,
   output logic [N_NEURONS-1:0]             spikes,
   output logic                             busy
);

   localparam int IDX_W = $clog2(N_NEURONS);

   lif_state_e                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [N_IN-1:0]            in_q;
   logic [N_IN-1:0]            w_q [N_NEURONS];
   logic signed [MEM_W-1:0]    mem_q [N_NEURONS];
   logic [N_NEURONS-1:0]       was_q, was_d;
   logic [N_NEURONS-1:0]       spikes_q, spikes_d;

   logic signed [MEM_W-1:0]    core_u;
   logic                       core_spk;
   logic signed [MEM_W-1:0]    upd_u;
   logic                       upd_spk;
   logic                       last_idx;

   assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

   lif_neuron_core #(
      .N_IN  (N_IN),
      .MEM_W (MEM_W)
   ) u_core (
      .in_vec_i    (in_q),
      .weights_i   (w_q[idx_q]),
      .mem_i       (mem_q[idx_q]),
      .was_spike_i (was_q[idx_q]),
      .threshold_i (threshold),
      .shift_i     (shift),
      .mem_o       (core_u),
      .spike_o     (core_spk)
   );

`ifdef LIF_REFRACTORY_EN
   localparam int RC_W = $clog2(REFRACT + 1);
   logic [RC_W-1:0] refr_q [N_NEURONS];
   logic            in_refr;
   assign in_refr = (refr_q[idx_q] != '0);
`endif

   always_comb begin
      upd_u   = core_u;
      upd_spk = core_spk;
`ifdef LIF_REFRACTORY_EN
      if (in_refr) begin
         upd_u   = '0;
         upd_spk = 1'b0;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               idx_d   = '0;
            end
         end
         RUN: begin
            if (last_idx) state_d = DONE;
            else          idx_d   = idx_q + IDX_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The output vector only changes when the last neuron lands, so it stays stable during RUN.
   always_comb begin
      was_d    = was_q;
      spikes_d = spikes_q;
      if (state_q == RUN) begin
         was_d[idx_q] = upd_spk;
         if (last_idx) spikes_d = was_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         in_q     <= '0;
         was_q    <= '0;
         spikes_q <= '0;
         for (int n = 0; n < N_NEURONS; n++) begin
            w_q[n]   <= '0;
            mem_q[n] <= '0;
`ifdef LIF_REFRACTORY_EN
            refr_q[n] <= '0;
`endif
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         was_q    <= was_d;
         spikes_q <= spikes_d;
         if (state_q == IDLE) begin
            if (in_valid) in_q <= inputs;
            if (cfg_we)   w_q[cfg_addr] <= cfg_weights;
         end
         if (state_q == RUN) begin
            mem_q[idx_q] <= upd_u;
`ifdef LIF_REFRACTORY_EN
            if (in_refr)      refr_q[idx_q] <= refr_q[idx_q] - RC_W'(1);
            else if (upd_spk) refr_q[idx_q] <= RC_W'(REFRACT);
`endif
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign spikes    = spikes_q;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Randomized and directed bench for lif_neuron_layer against an arithmetic reference model.
module tb_lif_neuron_layer;

   localparam int N_IN      = 8;
   localparam int N_NEURONS = 4;
   localparam int MEM_W     = 6;
   localparam int IDX_W     = $clog2(N_NEURONS);
   localparam int MEM_MAX   = (1 << (MEM_W - 1)) - 1;
   localparam int MEM_MIN   = -(1 << (MEM_W - 1));
`ifdef LIF_REFRACTORY_EN
   localparam int REFRACT   = 2;
`endif

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        cfg_we;
   logic [IDX_W-1:0]            cfg_addr;
   logic [N_IN-1:0]             cfg_weights;
   logic signed [MEM_W-1:0]     threshold;
   logic [2:0]                  shift;
   logic                        in_valid;
   logic                        in_ready;
   logic [N_IN-1:0]             inputs;
   logic                        out_valid;
   logic [N_NEURONS-1:0]        spikes;
   logic                        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [N_IN-1:0]      m_w [N_NEURONS];
   int                   m_u [N_NEURONS];
   logic [N_NEURONS-1:0] m_spk;
`ifdef LIF_REFRACTORY_EN
   int                   m_r [N_NEURONS];
`endif

   always #5 clk = ~clk;

   lif_neuron_layer #(
      .N_IN      (N_IN),
      .N_NEURONS (N_NEURONS),
      .MEM_W     (MEM_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_weights (cfg_weights),
      .threshold   (threshold),
      .shift       (shift),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .inputs      (inputs),
      .out_valid   (out_valid),
      .spikes      (spikes),
      .busy        (busy)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < N_NEURONS; n++) begin
         m_w[n] = '0;
         m_u[n] = 0;
`ifdef LIF_REFRACTORY_EN
         m_r[n] = 0;
`endif
      end
      m_spk = '0;
   endtask

   // One timestep for every neuron, straight from the neuron equations.
   task automatic model_step(input logic [N_IN-1:0] x, input int thr, input int sh);
      for (int n = 0; n < N_NEURONS; n++) begin
         int s;
         int b;
         int p;
         bit f;
         s = 0;
         for (int i = 0; i < N_IN; i++)
            if (x[i]) s += m_w[n][i] ? 1 : -1;
         b = (sh == 0) ? m_u[n] : m_u[n] - (m_u[n] >>> sh);
         p = b + s - (m_spk[n] ? thr : 0);
         if (p > MEM_MAX) p = MEM_MAX;
         if (p < MEM_MIN) p = MEM_MIN;
         f = (p >= thr);
`ifdef LIF_REFRACTORY_EN
         if (m_r[n] > 0) begin
            p = 0;
            f = 1'b0;
            m_r[n]--;
         end else if (f) begin
            m_r[n] = REFRACT;
         end
`endif
         m_u[n]   = p;
         m_spk[n] = f;
      end
   endtask

   task automatic chk_mems(input string tag);
      for (int k = 0; k < N_NEURONS; k++)
         chk($sformatf("%s_mem%0d", tag, k), int'(dut.mem_q[k]), m_u[k]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic cfg_write(input int addr, input logic [N_IN-1:0] wv);
      cfg_we      = 1'b1;
      cfg_addr    = IDX_W'(addr);
      cfg_weights = wv;
      @(negedge clk);
      cfg_we = 1'b0;
      m_w[addr] = wv;
   endtask

   // mode 0: no config write; 1: write alongside the accept; 2: write attempted during RUN.
   task automatic step(input logic [N_IN-1:0] x, input int thr, input int sh,
                       input int mode, input int addr, input logic [N_IN-1:0] wv);
      logic [N_NEURONS-1:0] prev;
      int lat;
      prev = m_spk;
      chk("rdy_idle", int'(in_ready), 1);
      in_valid  = 1'b1;
      inputs    = x;
      threshold = MEM_W'(thr);
      shift     = 3'(sh);
      if (mode == 1) begin
         cfg_we = 1'b1; cfg_addr = IDX_W'(addr); cfg_weights = wv;
         m_w[addr] = wv;
      end
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      lat      = 1;
      chk("busy_run", int'(busy), 1);
      chk("rdy_run", int'(in_ready), 0);
      if (mode == 2) begin
         cfg_we = 1'b1; cfg_addr = IDX_W'(addr); cfg_weights = wv;
      end
      @(negedge clk);
      cfg_we = 1'b0;
      lat    = 2;
      chk("spk_hold", int'(spikes), int'(prev));
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, N_NEURONS + 1);
      model_step(x, thr, sh);
      chk("spikes", int'(spikes), int'(m_spk));
      chk_mems("step");
      @(negedge clk);
      chk("ov_pulse", int'(out_valid), 0);
      chk("rdy_after", int'(in_ready), 1);
   endtask

   initial begin
      int acc[$];
      int ov[$];
      int seen;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_weights = '0;
      threshold = MEM_W'(5); shift = 3'd0; in_valid = 1'b0; inputs = '0;
      @(negedge clk);
      do_reset();

      chk("rst_ready", int'(in_ready), 1);
      chk("rst_ov", int'(out_valid), 0);
      chk("rst_spikes", int'(spikes), 0);
      chk("rst_busy", int'(busy), 0);
      chk_mems("rst");

      // Positive integration up to the clamp
      for (int n = 0; n < N_NEURONS; n++) cfg_write(n, 8'hFF);
      for (int t = 0; t < 10; t++) step(8'hFF, 5, 0, 0, 0, '0);
      chk("sat_hi_u0", int'(dut.mem_q[0]), 31);
      chk("sat_hi_spk", int'(spikes), 4'hF);

      // Negative saturation (reset leaves all weights at -1)
      do_reset();
      for (int t = 0; t < 6; t++) step(8'hFF, 5, 0, 0, 0, '0);
      chk("sat_lo_u0", int'(dut.mem_q[0]), -32);
      chk("sat_lo_spk", int'(spikes), 0);

      // Leak
      do_reset();
      cfg_write(0, 8'hFF);
      step(8'hFF, 20, 0, 0, 0, '0);
      chk("leak_start", int'(dut.mem_q[0]), 8);
      step(8'h00, 20, 0, 0, 0, '0);
      chk("leak_none", int'(dut.mem_q[0]), 8);
      for (int t = 0; t < 4; t++) step(8'h00, 20, 1, 0, 0, '0);
      chk("leak_end", int'(dut.mem_q[0]), 1);

      // Back-to-back handshake with in_valid held high
      inputs = 8'hA5; threshold = MEM_W'(3); shift = 3'd2; in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (in_ready) acc.push_back(c);
         if (out_valid) ov.push_back(c);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("hs_accepts", acc.size(), 2);
      chk("hs_outs", ov.size(), 2);
      chk("hs_latency", (acc.size() > 0 && ov.size() > 0) ? ov[0] - acc[0] : -1, N_NEURONS + 1);
      chk("hs_spacing", (acc.size() > 1) ? acc[1] - acc[0] : -1, N_NEURONS + 2);
      model_step(8'hA5, 3, 2);
      model_step(8'hA5, 3, 2);
      chk("hs_spikes", int'(spikes), int'(m_spk));
      chk_mems("hs");

      // Config gating
      do_reset();
      step(8'hFF, 4, 0, 2, 2, 8'hFF);
      chk("gate_run_u2", int'(dut.mem_q[2]), -8);
      step(8'hFF, 4, 0, 1, 2, 8'hFF);
      chk("gate_idle_u2", int'(dut.mem_q[2]), 0);
      cfg_write(1, 8'h0F);
      step(8'h3C, 2, 0, 0, 0, '0);

      // Reset in the middle of RUN at idx 2
      for (int n = 0; n < N_NEURONS; n++) cfg_write(n, 8'hFF);
      step(8'hFF, 5, 0, 0, 0, '0);
      in_valid = 1'b1; inputs = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chk("mid_rst_ov", int'(out_valid), 0);
      chk("mid_rst_spikes", int'(spikes), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      chk_mems("mid_rst");
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      chk("mid_rst_no_ov", seen, 0);

      // Randomized timesteps
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0)
            cfg_write(int'($urandom_range(0, N_NEURONS - 1)), N_IN'($urandom));
         step(N_IN'($urandom), int'($urandom_range(1, MEM_MAX)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, N_NEURONS - 1)), N_IN'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
